// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared state type and default geometry for the dual-port sync RAM
package sync_ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_t;

endpackage

// File: rtl/sync_ram_init_fsm.sv
// rtl/sync_ram_init_fsm.sv - clear sequencer that zero-fills every RAM address after reset
module sync_ram_init_fsm
    import sync_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    ram_state_t        state;
    ram_state_t        state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    // State and clear-address registers; reset always restarts the clear from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // One address cleared per INIT cycle; leave INIT once the top address has been written
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        init_busy  = 1'b0;
        clr_we     = 1'b0;
        clr_addr   = cnt;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_next = READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + ADDR_ONE;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule

// File: rtl/sync_ram_dp.sv
// rtl/sync_ram_dp.sv - dual-port synchronous RAM with byte enables and zero-fill; optional RAM_BYPASS_EN forwarding
module sync_ram_dp
    import sync_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                init_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_word;

    sync_ram_init_fsm #(
        .ADDR_W (ADDR_W)
    ) u_init_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we)
    );

    // User traffic is only honoured once the clear engine has finished
    assign wr_accept = wr_en & ~init_busy;
    assign rd_accept = rd_en & ~init_busy;

    // Array write: zero-fill during INIT, byte-masked user writes in READY; array itself is never reset
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_BYPASS_EN
    // Same-address collision returns the incoming bytes merged over the stored word
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_accept && (wr_addr == rd_addr)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end
`else
    // Plain array read: a same-cycle write to the same address is not yet visible (old data)
    always_comb begin
        rd_word = mem[rd_addr];
    end
`endif

    // Registered read port; rd_data holds its last value when no read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_sync_ram_dp.sv
// tb/tb_sync_ram_dp.sv - self-checking bench for sync_ram_dp with table vectors and a random reference model
module tb_sync_ram_dp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int BE_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [BE_W-1:0]   wr_be = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_busy;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] model_rd = '0;
    int                model_left = DEPTH;

    typedef struct {
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic [BE_W-1:0]   wr_be;
        logic              rd_en;
        logic [ADDR_W-1:0] rd_addr;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs [18];

    sync_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] data,
                                                input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    // One clock with the currently driven inputs; the model predicts the outputs after the edge
    task automatic tick();
        logic              exp_v;
        logic [DATA_W-1:0] exp_d;
        exp_v = 1'b0;
        exp_d = model_rd;
        if (model_left == 0) begin
            if (rd_en) begin
                exp_v = 1'b1;
                exp_d = ref_mem[rd_addr];
`ifdef RAM_BYPASS_EN
                if (wr_en && wr_addr == rd_addr) exp_d = merge(ref_mem[rd_addr], wr_data, wr_be);
`endif
            end
            if (wr_en) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
        end else begin
            model_left--;
        end
        @(posedge clk);
        #1;
        model_rd = exp_d;
        chk("model_rd_valid", {31'b0, rd_valid}, {31'b0, exp_v});
        chk("model_rd_data", rd_data, exp_d);
        chk("model_init_busy", {31'b0, init_busy}, {31'b0, model_left > 0});
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = '0;
    endtask

    // Assert reset asynchronously, check forced outputs, then release after hold clocks
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("rst_init_busy", {31'b0, init_busy}, 32'h1);
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_hold_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("rst_hold_rd_data", rd_data, 32'h0);
        rst_n = 1'b1;
        model_left = DEPTH;
        model_rd   = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic run_init(output int n, output int seen);
        n = 0;
        seen = 0;
        while (init_busy === 1'b1 && n < 400) begin
            tick();
            if (rd_valid) seen++;
            n++;
        end
    endtask

    initial begin
        int n;
        int seen;
        logic [DATA_W-1:0] coll_exp;

`ifdef RAM_BYPASS_EN
        coll_exp = 32'h0000_005A;
`else
        coll_exp = 32'h0000_0000;
`endif
        vecs[0]  = '{1'b1, 8'd5,  32'hAABBCCDD, 4'b1111, 1'b0, 8'd0,  1'b0, 32'h0};
        vecs[1]  = '{1'b1, 8'd5,  32'h11223344, 4'b0101, 1'b0, 8'd0,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b1, 8'd5,  1'b1, 32'hAA22CC44};
        vecs[3]  = '{1'b1, 8'd7,  32'h0000005A, 4'b1111, 1'b1, 8'd7,  1'b1, coll_exp};
        vecs[4]  = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b1, 8'd7,  1'b1, 32'h5A};
        vecs[5]  = '{1'b1, 8'd9,  32'h12345678, 4'b0000, 1'b1, 8'd9,  1'b1, 32'h0};
        vecs[6]  = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b1, 8'd9,  1'b1, 32'h0};
        vecs[7]  = '{1'b1, 8'd0,  32'h100,      4'b1111, 1'b0, 8'd0,  1'b0, 32'h0};
        vecs[8]  = '{1'b1, 8'd1,  32'h101,      4'b1111, 1'b0, 8'd0,  1'b0, 32'h0};
        vecs[9]  = '{1'b1, 8'd2,  32'h102,      4'b1111, 1'b0, 8'd0,  1'b0, 32'h0};
        vecs[10] = '{1'b1, 8'd3,  32'h103,      4'b1111, 1'b0, 8'd0,  1'b0, 32'h0};
        vecs[11] = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b1, 8'd0,  1'b1, 32'h100};
        vecs[12] = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b1, 8'd1,  1'b1, 32'h101};
        vecs[13] = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b1, 8'd2,  1'b1, 32'h102};
        vecs[14] = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b1, 8'd3,  1'b1, 32'h103};
        vecs[15] = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b0, 8'd0,  1'b0, 32'h103};
        vecs[16] = '{1'b1, 8'd20, 32'hCAFEF00D, 4'b1111, 1'b1, 8'd0,  1'b1, 32'h100};
        vecs[17] = '{1'b0, 8'd0,  32'h0,        4'b0000, 1'b1, 8'd20, 1'b1, 32'hCAFEF00D};

        do_reset(3);

        // Requests held through INIT (including the release cycle) must be ignored
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'hFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd3;
        run_init(n, seen);
        chk("init_cycles", n, 256);
        chk("init_rd_valid_seen", seen, 0);
        idle();
        rd_en = 1'b1; rd_addr = 8'd3;
        tick();
        chk("init_addr3_valid", {31'b0, rd_valid}, 32'h1);
        chk("init_addr3_data", rd_data, 32'h0);
        rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        tick();
        chk("init_any_addr_data", rd_data, 32'h0);
        idle();

        for (int i = 0; i < 18; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            wr_be   = vecs[i].wr_be;
            rd_en   = vecs[i].rd_en;
            rd_addr = vecs[i].rd_addr;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
        end
        idle();

        // Random traffic over a small address window so collisions are frequent
        for (int c = 0; c < 400; c++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = ADDR_W'($urandom_range(0, 15));
            wr_data = $urandom;
            wr_be   = BE_W'($urandom_range(0, 15));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ADDR_W'($urandom_range(0, 15));
            tick();
        end
        idle();
        rd_en = 1'b1; rd_addr = 8'd20;
        tick();
        idle();

        // Reset while READY: outputs forced low, full clear restarts
        do_reset(2);
        run_init(n, seen);
        chk("ready_reset_init_cycles", n, 256);
        rd_en = 1'b1; rd_addr = 8'd5;
        tick();
        chk("ready_reset_addr5_cleared", rd_data, 32'h0);
        idle();

        // Reset while the clear address is 100
        do_reset(2);
        repeat (100) tick();
        do_reset(2);
        run_init(n, seen);
        chk("mid_init_reset_cycles", n, 256);
        rd_en = 1'b1; rd_addr = 8'd100;
        tick();
        chk("mid_init_addr100_valid", {31'b0, rd_valid}, 32'h1);
        idle();
        tick();
        chk("final_rd_valid_low", {31'b0, rd_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
